hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Parametrised successor to the pipeline hazard detector. Sits beside the ID stage of the 5-stage ARM pipeline.
- Handles three pipeline events:
  - Load-use stalls.
  - Forwarding selects, computed in ID and registered so they are aligned with the EXE stage.
  - Whole-pipeline freeze while data memory is busy, with a wait counter and timeout flag.
- `forwardEn=0` reproduces the legacy stall-on-any-match behaviour.

Parameters:
- REG_W, 4, register address width.
- NUM_SRC, 2, number of ID-stage source operands (2..4).
- MAX_WAIT, 15, maximum memory-wait cycles before `memTimeout` is set (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- srcs  in  NUM_SRC*REG_W  ID-stage source register numbers; src i is at [i*REG_W +: REG_W].
- srcValid  in  NUM_SRC  per-source "operand is read" flag.
- destEXE  in  REG_W  destination register of the instruction in EXE.
- wbEnEXE  in  1  EXE instruction writes back.
- memReadEXE  in  1  EXE instruction is a load.
- destMEM  in  REG_W  destination register of the instruction in MEM.
- wbEnMEM  in  1  MEM instruction writes back.
- memAccessMEM  in  1  MEM instruction accesses data memory.
- memReady  in  1  data memory handshake complete.
- forwardEn  in  1  forwarding mode enable.
- flush  in  1  taken branch; squash the ID instruction.
- hazardDetected  out  1  combinational; stall PC and IF/ID, insert bubble into ID/EXE.
- freeze  out  1  combinational; hold every pipeline register.
- fwdSel  out  NUM_SRC*2  registered; per-source select for the EXE-stage instruction (00 regfile, 01 MEM-stage ALU result, 10 WB-stage value).
- memTimeout  out  1  sticky error flag.

Behaviour:
- Reset (rst low, async): fwdSel=0, memTimeout=0, FSM=RUN, wait counter=0. Combinational outputs follow their inputs.
- Per source i, define:
  - hitE(i) = srcValid[i] && wbEnEXE && src_i==destEXE
  - hitM(i) = srcValid[i] && wbEnMEM && src_i==destMEM
- hazardDetected:
  - forwardEn=0: OR over i of (hitE | hitM).
  - forwardEn=1: OR over i of (hitE && memReadEXE). This is the load-use case only.
- freeze = memAccessMEM && !memReady. freeze dominates: hazardDetected still drives, but the top level holds all registers.
- Next fwdSel per source, when forwardEn=1:
  - hitE && !memReadEXE → 01.
  - Otherwise hitM → 10.
  - Otherwise 00.
  - EXE match has priority over MEM match.
- fwdSel register update, in priority order:
  - freeze=1: hold.
  - Else flush=1 or hazardDetected=1: load all zeros (bubble).
  - Else forwardEn=0: load all zeros.
  - Else load next fwdSel.
- FSM RUN ↔ MEM_WAIT:
  - RUN → MEM_WAIT when freeze=1; the counter loads 1.
  - In MEM_WAIT, the counter increments each cycle freeze stays 1, saturating at MAX_WAIT.
  - If freeze=1 while the counter already equals MAX_WAIT, memTimeout is set.
  - MEM_WAIT → RUN when memReady=1 or memAccessMEM=0; the counter clears.
  - memTimeout clears only on reset.
- A single-cycle access (memReady=1 in the same cycle as memAccessMEM) never leaves RUN.
- Reset asserted mid-wait returns to RUN immediately.
- Width rules:
  - Counter width is ceil(log2(MAX_WAIT+1)).
  - Comparisons are full REG_W equality.
  - Register 15 is not special-cased.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - stallCount (16 bits): counts cycles with hazardDetected=1 and freeze=0.
  - freezeCount (16 bits): counts cycles with freeze=1.
- Both counters saturate at 0xFFFF, reset to 0, and clear synchronously on input perfClr (1 bit).
- When undefined, these ports and the counter logic are absent.

Test Plan:
- forwardEn=1, src0=3, srcValid=01, destEXE=3, wbEnEXE=1, memReadEXE=0 → hazardDetected=0; next cycle fwdSel[1:0]=01.
- forwardEn=1, src1=5, destEXE=5, memReadEXE=1, wbEnEXE=1 → hazardDetected=1; next cycle fwdSel=0. Then destMEM=5, wbEnMEM=1, EXE cleared → next fwdSel[3:2]=10.
- src0=2 matches both destEXE=2 and destMEM=2, wbEn both 1, no load → fwdSel[1:0]=01 (EXE priority).
- forwardEn=0, src0=7, destMEM=7, wbEnMEM=1 → hazardDetected=1, fwdSel stays 0.
- memAccessMEM=1, memReady=0 for 4 cycles → freeze=1 throughout and fwdSel held. memReady=1 → FSM back to RUN, memTimeout=0. Repeat with MAX_WAIT=3 and 5 wait cycles → memTimeout=1 and stays set.
- Assert rst low mid-MEM_WAIT with fwdSel=01 → fwdSel=0, FSM=RUN, memTimeout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, EXE-aligned forwarding selects and memory-wait freeze control for a 5-stage pipeline.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall/freeze performance counters.
module hazard_forward_ctrl #(
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*REG_W-1:0] srcs,
  input  logic [NUM_SRC-1:0]       srcValid,
  input  logic [REG_W-1:0]         destEXE,
  input  logic                     wbEnEXE,
  input  logic                     memReadEXE,
  input  logic [REG_W-1:0]         destMEM,
  input  logic                     wbEnMEM,
  input  logic                     memAccessMEM,
  input  logic                     memReady,
  input  logic                     forwardEn,
  input  logic                     flush,
  output logic                     hazardDetected,
  output logic                     freeze,
  output logic [NUM_SRC*2-1:0]     fwdSel,
  output logic                     memTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic                     perfClr,
  output logic [15:0]              stallCount,
  output logic [15:0]              freezeCount
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  logic [NUM_SRC-1:0]   hit_e;
  logic [NUM_SRC-1:0]   hit_m;
  logic [NUM_SRC*2-1:0] fwd_next;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_d;

  // Per-source match detection and the select the instruction will need once it reaches EXE.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    hit_e    = '0;
    hit_m    = '0;
    fwd_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_e[i] = srcValid[i] && wbEnEXE && (srcs[i*REG_W +: REG_W] == destEXE);
      hit_m[i] = srcValid[i] && wbEnMEM && (srcs[i*REG_W +: REG_W] == destMEM);
      if (hit_e[i] && !memReadEXE) begin
        fwd_next[i*2 +: 2] = 2'b01;
      end else if (hit_m[i]) begin
        fwd_next[i*2 +: 2] = 2'b10;
      end
    end
  end

  // With forwarding only a load in EXE cannot be bypassed in time; legacy mode stalls on any match.
  assign hazardDetected = forwardEn ? ((|hit_e) && memReadEXE) : (|(hit_e | hit_m));
  assign freeze         = memAccessMEM && !memReady;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      fwdSel <= '0;
    end else if (!freeze) begin
      if (flush || hazardDetected || !forwardEn) begin
        fwdSel <= '0;
      end else begin
        fwdSel <= fwd_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      memTimeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      memTimeout <= timeout_d;
    end
  end

  // Memory wait tracking; the timeout flag is sticky until reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = memTimeout;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= '0;
    end else if (perfClr) begin
      stallCount <= '0;
    end else if (hazardDetected && !freeze && (stallCount != 16'hFFFF)) begin
      stallCount <= stallCount + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freezeCount <= '0;
    end else if (perfClr) begin
      freezeCount <= '0;
    end else if (freeze && (freezeCount != 16'hFFFF)) begin
      freezeCount <= freezeCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench for hazard_forward_ctrl: a default instance plus a MAX_WAIT=3 instance for timeout checks.
module tb_hazard_forward_ctrl;

  localparam int HZ   = 0;
  localparam int FRZ  = 1;
  localparam int FWD  = 2;
  localparam int TO   = 3;
  localparam int TO3  = 4;
  localparam int FRZ3 = 5;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] srcs;
  logic [1:0] src_valid;
  logic [3:0] dest_exe;
  logic       wb_en_exe;
  logic       mem_read_exe;
  logic [3:0] dest_mem;
  logic       wb_en_mem;
  logic       mem_access;
  logic       mem_ready;
  logic       mem_access3;
  logic       mem_ready3;
  logic       forward_en;
  logic       flush;

  logic       hazard;
  logic       frz;
  logic [3:0] fwd_sel;
  logic       timeout;
  logic       hazard3;
  logic       frz3;
  logic [3:0] fwd_sel3;
  logic       timeout3;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [15:0] stall_cnt, freeze_cnt, stall_cnt3, freeze_cnt3;
`endif

  hazard_forward_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .srcs           (srcs),
    .srcValid       (src_valid),
    .destEXE        (dest_exe),
    .wbEnEXE        (wb_en_exe),
    .memReadEXE     (mem_read_exe),
    .destMEM        (dest_mem),
    .wbEnMEM        (wb_en_mem),
    .memAccessMEM   (mem_access),
    .memReady       (mem_ready),
    .forwardEn      (forward_en),
    .flush          (flush),
    .hazardDetected (hazard),
    .freeze         (frz),
    .fwdSel         (fwd_sel),
    .memTimeout     (timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perfClr        (perf_clr),
    .stallCount     (stall_cnt),
    .freezeCount    (freeze_cnt)
`endif
  );

  hazard_forward_ctrl #(.MAX_WAIT(3)) u_dut3 (
    .clk            (clk),
    .rst            (rst),
    .srcs           (srcs),
    .srcValid       (src_valid),
    .destEXE        (dest_exe),
    .wbEnEXE        (wb_en_exe),
    .memReadEXE     (mem_read_exe),
    .destMEM        (dest_mem),
    .wbEnMEM        (wb_en_mem),
    .memAccessMEM   (mem_access3),
    .memReady       (mem_ready3),
    .forwardEn      (forward_en),
    .flush          (flush),
    .hazardDetected (hazard3),
    .freeze         (frz3),
    .fwdSel         (fwd_sel3),
    .memTimeout     (timeout3)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perfClr        (perf_clr),
    .stallCount     (stall_cnt3),
    .freezeCount    (freeze_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      HZ:      return {7'd0, hazard};
      FRZ:     return {7'd0, frz};
      FWD:     return {4'd0, fwd_sel};
      TO:      return {7'd0, timeout};
      TO3:     return {7'd0, timeout3};
      FRZ3:    return {7'd0, frz3};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push_c(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    comb_q.push_back(e);
  endtask

  task automatic push_r(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    reg_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [7:0] obs;
    obs = observe(e.sel);
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic drain_comb();
    while (comb_q.size() > 0) compare(comb_q.pop_front());
  endtask

  task automatic drain_reg();
    while (reg_q.size() > 0) compare(reg_q.pop_front());
  endtask

  // Combinational expectations are compared on the falling edge, registered ones just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    drain_comb();
    @(posedge clk);
    #1;
    drain_reg();
  endtask

  task automatic idle();
    srcs = '0; src_valid = '0; dest_exe = '0; wb_en_exe = 0; mem_read_exe = 0;
    dest_mem = '0; wb_en_mem = 0; mem_access = 0; mem_ready = 0; forward_en = 1; flush = 0;
  endtask

  // Forwarding-mode EXE hit on src0 (reg 15), leaving fwdSel = 0001.
  task automatic prime_fwd(input string tag);
    idle();
    srcs[3:0] = 4'd15; srcs[7:4] = 4'd15; src_valid = 2'b01; dest_exe = 4'd15; wb_en_exe = 1;
    push_c({tag, "_hz"}, HZ, 8'h0);
    push_r({tag, "_fwd"}, FWD, 8'h01);
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    mem_access3 = 0; mem_ready3 = 0;
    mem_access = 1;
    #2;
    push_r("rst_fwd", FWD, 8'h0);
    push_r("rst_to", TO, 8'h0);
    push_r("rst_to3", TO3, 8'h0);
    drain_reg();
    push_c("rst_freeze_comb", FRZ, 8'h1);
    drain_comb();
    mem_access = 0;
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // EXE ALU result forwarded
    idle(); srcs[3:0] = 4'd3; src_valid = 2'b01; dest_exe = 4'd3; wb_en_exe = 1;
    push_c("exe_fwd_hz", HZ, 8'h0); push_c("exe_fwd_frz", FRZ, 8'h0);
    push_r("exe_fwd_sel", FWD, 8'h01);
    cycle();

    // Load-use stall on src1 inserts a bubble
    idle(); srcs[7:4] = 4'd5; src_valid = 2'b10; dest_exe = 4'd5; wb_en_exe = 1; mem_read_exe = 1;
    push_c("load_use_hz", HZ, 8'h1);
    push_r("load_use_fwd", FWD, 8'h0);
    cycle();

    // Load now in MEM: forward WB value to src1
    idle(); srcs[7:4] = 4'd5; src_valid = 2'b10; dest_mem = 4'd5; wb_en_mem = 1;
    push_c("mem_fwd_hz", HZ, 8'h0);
    push_r("mem_fwd_sel", FWD, 8'h08);
    cycle();

    // EXE match has priority over MEM match
    idle(); srcs[3:0] = 4'd2; src_valid = 2'b01; dest_exe = 4'd2; wb_en_exe = 1; dest_mem = 4'd2; wb_en_mem = 1;
    push_c("prio_hz", HZ, 8'h0);
    push_r("prio_fwd", FWD, 8'h01);
    cycle();

    // Both sources forwarded from different stages
    idle(); srcs = {4'd6, 4'd4}; src_valid = 2'b11; dest_exe = 4'd4; wb_en_exe = 1; dest_mem = 4'd6; wb_en_mem = 1;
    push_c("dual_hz", HZ, 8'h0);
    push_r("dual_fwd", FWD, 8'h09);
    cycle();

    // Same, but EXE is a load: stall wins
    mem_read_exe = 1;
    push_c("dual_load_hz", HZ, 8'h1);
    push_r("dual_load_fwd", FWD, 8'h0);
    cycle();

    prime_fwd("r15");

    // Flush squashes the selects
    idle(); srcs[3:0] = 4'd3; src_valid = 2'b01; dest_exe = 4'd3; wb_en_exe = 1; flush = 1;
    push_c("flush_hz", HZ, 8'h0);
    push_r("flush_fwd", FWD, 8'h0);
    cycle();

    prime_fwd("pre_valid");

    // Unread operands never match
    idle(); srcs = {4'd9, 4'd9}; src_valid = 2'b00; dest_exe = 4'd9; wb_en_exe = 1; mem_read_exe = 1;
    dest_mem = 4'd9; wb_en_mem = 1;
    push_c("valid_gate_hz", HZ, 8'h0);
    push_r("valid_gate_fwd", FWD, 8'h0);
    cycle();

    prime_fwd("pre_legacy");

    // Legacy mode: any match stalls, fwdSel stays zero
    idle(); forward_en = 0; srcs[3:0] = 4'd7; src_valid = 2'b01; dest_mem = 4'd7; wb_en_mem = 1;
    push_c("legacy_mem_hz", HZ, 8'h1);
    push_r("legacy_mem_fwd", FWD, 8'h0);
    cycle();

    idle(); forward_en = 0; srcs[3:0] = 4'd3; src_valid = 2'b01; dest_exe = 4'd3; wb_en_exe = 1;
    push_c("legacy_exe_hz", HZ, 8'h1);
    cycle();

    prime_fwd("pre_legacy_nomatch");

    idle(); forward_en = 0; srcs[3:0] = 4'd3; src_valid = 2'b01; dest_exe = 4'd4; wb_en_exe = 1;
    push_c("legacy_nomatch_hz", HZ, 8'h0);
    push_r("legacy_nomatch_fwd", FWD, 8'h0);
    cycle();

    prime_fwd("pre_freeze");

    // Four-cycle memory wait: everything held, stall still visible
    for (int k = 0; k < 4; k++) begin
      idle(); mem_access = 1;
      if (k == 1) begin
        srcs[3:0] = 4'd4; src_valid = 2'b01; dest_exe = 4'd4; wb_en_exe = 1; mem_read_exe = 1;
      end
      push_c($sformatf("freeze%0d_frz", k), FRZ, 8'h1);
      push_c($sformatf("freeze%0d_hz", k), HZ, (k == 1) ? 8'h1 : 8'h0);
      push_r($sformatf("freeze%0d_fwd", k), FWD, 8'h01);
      push_r($sformatf("freeze%0d_to", k), TO, 8'h0);
      cycle();
    end

    idle(); mem_access = 1; mem_ready = 1; srcs[7:4] = 4'd6; src_valid = 2'b10; dest_mem = 4'd6; wb_en_mem = 1;
    push_c("mem_done_frz", FRZ, 8'h0);
    push_r("mem_done_fwd", FWD, 8'h08);
    push_r("mem_done_to", TO, 8'h0);
    cycle();

    idle();
    push_r("post_wait_fwd", FWD, 8'h0);
    push_r("post_wait_to", TO, 8'h0);
    cycle();

    // MAX_WAIT=3 instance: single-cycle accesses never freeze
    for (int k = 0; k < 3; k++) begin
      mem_access3 = 1; mem_ready3 = 1;
      push_c($sformatf("single%0d_frz3", k), FRZ3, 8'h0);
      push_r($sformatf("single%0d_to3", k), TO3, 8'h0);
      cycle();
    end

    // Exactly MAX_WAIT freeze cycles, twice: no timeout, counter clears between
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 3; k++) begin
        mem_access3 = 1; mem_ready3 = 0;
        push_c($sformatf("w3_%0d_%0d_frz3", rep, k), FRZ3, 8'h1);
        push_r($sformatf("w3_%0d_%0d_to3", rep, k), TO3, 8'h0);
        cycle();
      end
      mem_access3 = 1; mem_ready3 = 1;
      push_r($sformatf("w3_%0d_rel_to3", rep), TO3, 8'h0);
      cycle();
    end

    // Five wait cycles: timeout after the fourth
    for (int k = 0; k < 5; k++) begin
      mem_access3 = 1; mem_ready3 = 0;
      push_r($sformatf("w5_%0d_to3", k), TO3, (k >= 3) ? 8'h1 : 8'h0);
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      mem_access3 = 0; mem_ready3 = 0;
      push_r($sformatf("sticky%0d_to3", k), TO3, 8'h1);
      push_r($sformatf("sticky%0d_to", k), TO, 8'h0);
      cycle();
    end

    // Asynchronous reset in the middle of a wait
    prime_fwd("pre_rst");
    for (int k = 0; k < 2; k++) begin
      idle(); mem_access = 1;
      mem_access3 = 1; mem_ready3 = 0;
      push_r($sformatf("rst_wait%0d_fwd", k), FWD, 8'h01);
      cycle();
    end
    #2 rst = 1'b0;
    #1;
    push_r("async_rst_fwd", FWD, 8'h0);
    push_r("async_rst_to", TO, 8'h0);
    push_r("async_rst_to3", TO3, 8'h0);
    drain_reg();
    push_c("async_rst_frz", FRZ, 8'h1);
    drain_comb();
    idle(); mem_access3 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Counter restarted from RUN: exactly MAX_WAIT cycles do not time out
    for (int k = 0; k < 3; k++) begin
      mem_access3 = 1; mem_ready3 = 0;
      push_r($sformatf("post_rst%0d_to3", k), TO3, 8'h0);
      cycle();
    end
    mem_access3 = 0;
    push_r("post_rst_rel_to3", TO3, 8'h0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
